draw_rect_stage: RTL and testbench
==================================

DRAW_RECT_STAGE -- requirements
Module: draw_rect_stage

Interface
REQ-001 Parameter RECT_W, default 48: rectangle width in pixels, range 1..1023.
REQ-002 Parameter RECT_H, default 64: rectangle height in pixels, range 1..1023.
REQ-003 Parameter RECT_COLOR, default 12'hF00: fill colour, 4:4:4 RGB.
REQ-004 Parameter BORDER_COLOR, default 12'hFFF: border colour, used only when RECT_BORDER_EN is defined.
REQ-005 Port clk_in, input, 1: pixel clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: reset; synchronous and active-low.
REQ-007 Port xpos / ypos, input, 12 each: rectangle top-left corner from the position controller.
REQ-008 Port hcount_in / vcount_in, input, 11 each: current pixel coordinates from timing.
REQ-009 Port hsync_in / vsync_in / hblnk_in / vblnk_in, input, 1 each: sync and blanking strobes.
REQ-010 Port rgb_in, input, 12: background pixel colour.
REQ-011 Ports hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, output, widths as inputs: delayed timing plus overlaid colour.

Function
REQ-012 The block SHALL delay every timing output (hcount, vcount, hsync, vsync, hblnk, vblnk) by exactly 2 clk_in cycles relative to its input.
REQ-013 The block SHALL delay rgb_out by exactly 2 cycles, so rgb_out stays aligned with the delayed timing outputs.
REQ-014 The block SHALL hold xpos and ypos in shadow registers x_lat and y_lat.
REQ-015 The shadow registers SHALL load only in the cycle where vblnk_in=1 and vblnk_in was 0 in the previous cycle (rising edge of vertical blanking).
REQ-016 The newly loaded shadow values SHALL take effect from the next input pixel onward.
REQ-017 Changes on xpos and ypos outside the load cycle SHALL have no effect on the current frame.
REQ-018 Stage 1 SHALL register hit = (hcount_in >= x_lat) and (hcount_in < x_lat+RECT_W) and (vcount_in >= y_lat) and (vcount_in < y_lat+RECT_H).
REQ-019 Stage 1 SHALL register edge = hit and the pixel lies on the first or last column, or the first or last row, of the rectangle.
REQ-020 All hit and edge comparisons SHALL use 13-bit unsigned arithmetic with no wrap-around, so x_lat+RECT_W beyond 4095 clips at the screen edge and never wraps to column 0.
REQ-021 Stage 2 SHALL select rgb_out with this priority: blanked pixel (delayed hblnk or vblnk = 1) -> 12'h000; else hit -> rectangle colour; else the delayed rgb_in.
REQ-022 A rectangle lying wholly outside the active area SHALL leave rgb_out equal to the delayed rgb_in.
REQ-023 If rst_n is deasserted in the same cycle as a vblnk rising edge, reset SHALL take priority and no load SHALL occur.

Reset
REQ-024 While rst_n=0 at a clock edge, all outputs, both pipeline stages, x_lat, y_lat and the vblnk edge-detect register SHALL clear to 0.
REQ-025 After a reset in mid-frame, x_lat and y_lat SHALL remain 0 until the next vblnk rising edge; the rectangle draws at (0,0) until then.
REQ-026 Normal pipeline operation SHALL resume in the first cycle after rst_n returns to 1; the outputs are valid 2 cycles later.

Configuration
REQ-027 Macro RECT_BORDER_EN, when defined, SHALL draw edge pixels in BORDER_COLOR and the remaining hit pixels in RECT_COLOR.
REQ-028 Without RECT_BORDER_EN, every hit pixel SHALL be drawn in RECT_COLOR, and the edge logic SHALL be absent from the design.

Verification
REQ-029 Scenario: hsync_in pulse at cycle 10 -> hsync_out pulse at cycle 12; hcount_out equals hcount_in delayed by 2.
REQ-030 Scenario: load xpos=100, ypos=50 at a vblnk edge; rgb_in=12'h0A0 -> pixel (100,50) gives 12'hF00, (147,113) gives 12'hF00, (148,50) gives 12'h0A0, (100,114) gives 12'h0A0.
REQ-031 Scenario: change xpos from 100 to 300 mid-frame -> the current frame still draws at x=100; the next frame draws at x=300.
REQ-032 Scenario: xpos=4080, RECT_W=48 -> no hit at hcount 0..31; no wrap to the left edge.
REQ-033 Scenario: hblnk_in=1 inside the rectangle area -> rgb_out=12'h000.
REQ-034 Scenario: rst_n=0 for 1 cycle mid-frame -> all outputs 0 in the next cycle; the rectangle draws at (0,0) until the next vblnk edge. With RECT_BORDER_EN, pixel (100,50) after loading (100,50) gives 12'hFFF and (101,51) gives 12'hF00.

Source files
------------

// File: rtl/draw_rect_stage_if.sv
// Video timing bundle into and out of draw_rect_stage.
// slave: the drawing stage's view; master: the upstream timing source / downstream sink view.
interface draw_rect_stage_if;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
    );

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
    );
endinterface

// File: rtl/draw_rect_stage.sv
// Two-stage pipeline overlaying a filled rectangle on a video stream.
// Optional macro RECT_BORDER_EN draws the rectangle outline in BORDER_COLOR.
module draw_rect_stage #(
    parameter int          RECT_W       = 48,
    parameter int          RECT_H       = 64,
    parameter logic [11:0] RECT_COLOR   = 12'hF00,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    draw_rect_stage_if.slave vid
);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    logic        vblnk_prev_q, vblnk_prev_d;
    logic [11:0] x_lat_q, x_lat_d;
    logic [11:0] y_lat_q, y_lat_d;
    timing_t     s1_tim_q, s1_tim_d;
    logic [11:0] s1_rgb_q, s1_rgb_d;
    logic        s1_hit_q, s1_hit_d;
    timing_t     out_tim_q, out_tim_d;
    logic [11:0] rgb_out_q, rgb_out_d;
`ifdef RECT_BORDER_EN
    logic        s1_edge_q, s1_edge_d;
`endif

    logic        load;
    logic [12:0] h13, v13, x_beg, y_beg, x_end, y_end;
    logic [11:0] hit_color;

    always_comb begin
        load     = vid.vblnk_in & ~vblnk_prev_q;
        h13      = {2'b00, vid.hcount_in};
        v13      = {2'b00, vid.vcount_in};
        // 13-bit bounds: a rectangle running past column 4095 clips instead of wrapping
        x_beg    = {1'b0, x_lat_q};
        y_beg    = {1'b0, y_lat_q};
        x_end    = x_beg + 13'(RECT_W);
        y_end    = y_beg + 13'(RECT_H);

        vblnk_prev_d = vid.vblnk_in;
        x_lat_d      = load ? xpos : x_lat_q;
        y_lat_d      = load ? ypos : y_lat_q;

        s1_tim_d = '{hcount: vid.hcount_in, vcount: vid.vcount_in,
                     hsync:  vid.hsync_in,  vsync:  vid.vsync_in,
                     hblnk:  vid.hblnk_in,  vblnk:  vid.vblnk_in};
        s1_rgb_d = vid.rgb_in;
        s1_hit_d = (h13 >= x_beg) && (h13 < x_end) && (v13 >= y_beg) && (v13 < y_end);
`ifdef RECT_BORDER_EN
        s1_edge_d = s1_hit_d && ((h13 == x_beg) || (h13 == x_end - 13'd1) ||
                                 (v13 == y_beg) || (v13 == y_end - 13'd1));
        hit_color = s1_edge_q ? BORDER_COLOR : RECT_COLOR;
`else
        hit_color = RECT_COLOR;
`endif

        out_tim_d = s1_tim_q;
        if (s1_tim_q.hblnk || s1_tim_q.vblnk) begin
            rgb_out_d = '0;
        end else if (s1_hit_q) begin
            rgb_out_d = hit_color;
        end else begin
            rgb_out_d = s1_rgb_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            vblnk_prev_q <= 1'b0;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            s1_tim_q     <= '0;
            s1_rgb_q     <= '0;
            s1_hit_q     <= 1'b0;
            out_tim_q    <= '0;
            rgb_out_q    <= '0;
`ifdef RECT_BORDER_EN
            s1_edge_q    <= 1'b0;
`endif
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            s1_tim_q     <= s1_tim_d;
            s1_rgb_q     <= s1_rgb_d;
            s1_hit_q     <= s1_hit_d;
            out_tim_q    <= out_tim_d;
            rgb_out_q    <= rgb_out_d;
`ifdef RECT_BORDER_EN
            s1_edge_q    <= s1_edge_d;
`endif
        end
    end

    assign vid.hcount_out = out_tim_q.hcount;
    assign vid.vcount_out = out_tim_q.vcount;
    assign vid.hsync_out  = out_tim_q.hsync;
    assign vid.vsync_out  = out_tim_q.vsync;
    assign vid.hblnk_out  = out_tim_q.hblnk;
    assign vid.vblnk_out  = out_tim_q.vblnk;
    assign vid.rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_draw_rect_stage.sv
// Directed bench for draw_rect_stage: pipeline latency, shadow-register loading,
// clipping, blanking and reset behaviour (honours RECT_BORDER_EN).
module tb_draw_rect_stage;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [11:0] xpos, ypos;
    int          checks = 0;
    int          errors = 0;

`ifdef RECT_BORDER_EN
    localparam logic [11:0] EDGE_EXP = 12'hFFF;
`else
    localparam logic [11:0] EDGE_EXP = 12'hF00;
`endif

    draw_rect_stage_if vif();

    draw_rect_stage #(.RECT_W(48), .RECT_H(64), .RECT_COLOR(12'hF00), .BORDER_COLOR(12'hFFF)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .xpos   (xpos),
        .ypos   (ypos),
        .vid    (vif)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       name;
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [11:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                         input logic vb, input logic [11:0] rgb);
        vif.hcount_in = h;
        vif.vcount_in = v;
        vif.hsync_in  = 1'b0;
        vif.vsync_in  = 1'b0;
        vif.hblnk_in  = hb;
        vif.vblnk_in  = vb;
        vif.rgb_in    = rgb;
    endtask

    // Hold one pixel for two clocks and check the colour that emerges.
    task automatic px(input string name, input logic [10:0] h, input logic [10:0] v,
                      input logic [11:0] rgb, input logic [11:0] exp);
        drive(h, v, 1'b0, 1'b0, rgb);
        tick();
        tick();
        chk(name, {4'h0, vif.rgb_out}, {4'h0, exp});
    endtask

    task automatic load_pos(input logic [11:0] x, input logic [11:0] y);
        xpos = x;
        ypos = y;
        drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
        tick();
        vif.vblnk_in = 1'b1;
        tick();
        vif.vblnk_in = 1'b0;
        tick();
    endtask

    vec_t        tbl[10];
    logic [10:0] h_hist[20];
    logic        hs_hist[20];
    logic        vs_hist[20];
    logic [11:0] rgb_hist[20];

    initial begin
        tbl[0] = '{"top_left",     11'd100, 11'd50,  1'b0, 1'b0, 12'h0A0, EDGE_EXP};
        tbl[1] = '{"bot_right",    11'd147, 11'd113, 1'b0, 1'b0, 12'h0A0, EDGE_EXP};
        tbl[2] = '{"interior",     11'd101, 11'd51,  1'b0, 1'b0, 12'h0A0, 12'hF00};
        tbl[3] = '{"right_out",    11'd148, 11'd50,  1'b0, 1'b0, 12'h0A0, 12'h0A0};
        tbl[4] = '{"below_out",    11'd100, 11'd114, 1'b0, 1'b0, 12'h0A0, 12'h0A0};
        tbl[5] = '{"left_out",     11'd99,  11'd50,  1'b0, 1'b0, 12'h0A0, 12'h0A0};
        tbl[6] = '{"above_out",    11'd100, 11'd49,  1'b0, 1'b0, 12'h0A0, 12'h0A0};
        tbl[7] = '{"hblnk_inside", 11'd120, 11'd80,  1'b1, 1'b0, 12'h0A0, 12'h000};
        tbl[8] = '{"vblnk_inside", 11'd120, 11'd80,  1'b0, 1'b1, 12'h0A0, 12'h000};
        tbl[9] = '{"background",   11'd5,   11'd5,   1'b0, 1'b0, 12'h123, 12'h123};

        // Reset with busy inputs: everything must read zero.
        rst_n = 1'b0;
        xpos  = 12'd100;
        ypos  = 12'd50;
        drive(11'd321, 11'd123, 1'b1, 1'b1, 12'hABC);
        vif.hsync_in = 1'b1;
        vif.vsync_in = 1'b1;
        tick();
        tick();
        chk("rst_hcount", {5'h0, vif.hcount_out}, 16'h0);
        chk("rst_vcount", {5'h0, vif.vcount_out}, 16'h0);
        chk("rst_hsync",  {15'h0, vif.hsync_out}, 16'h0);
        chk("rst_vsync",  {15'h0, vif.vsync_out}, 16'h0);
        chk("rst_hblnk",  {15'h0, vif.hblnk_out}, 16'h0);
        chk("rst_vblnk",  {15'h0, vif.vblnk_out}, 16'h0);
        chk("rst_rgb",    {4'h0, vif.rgb_out},    16'h0);

        // Streaming: exact two-cycle latency on every timing signal and rgb.
        rst_n = 1'b1;
        drive(11'd0, 11'd300, 1'b0, 1'b0, 12'h000);
        tick();
        for (int c = 0; c < 20; c++) begin
            if (c >= 2) begin
                chk("lat_hcount", {5'h0, vif.hcount_out}, {5'h0, h_hist[c-2]});
                chk("lat_hsync",  {15'h0, vif.hsync_out}, {15'h0, hs_hist[c-2]});
                chk("lat_vsync",  {15'h0, vif.vsync_out}, {15'h0, vs_hist[c-2]});
                chk("lat_rgb",    {4'h0, vif.rgb_out},    {4'h0, rgb_hist[c-2]});
            end
            h_hist[c]   = 11'(500 + c);
            hs_hist[c]  = (c == 10);
            vs_hist[c]  = (c == 4);
            rgb_hist[c] = 12'(c * 37 + 1);
            drive(h_hist[c], 11'd300, 1'b0, 1'b0, rgb_hist[c]);
            vif.hsync_in = hs_hist[c];
            vif.vsync_in = vs_hist[c];
            tick();
        end

        // Table of single pixels against a rectangle loaded at (100,50).
        load_pos(12'd100, 12'd50);
        foreach (tbl[i]) begin
            drive(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].rgb);
            tick();
            tick();
            chk(tbl[i].name, {4'h0, vif.rgb_out}, {4'h0, tbl[i].exp});
            chk("tbl_hcount", {5'h0, vif.hcount_out}, {5'h0, tbl[i].h});
            chk("tbl_vcount", {5'h0, vif.vcount_out}, {5'h0, tbl[i].v});
        end

        // Mid-frame position change is ignored until the next vblnk rising edge.
        drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h0A0);
        tick();
        xpos = 12'd300;
        px("midframe_old",  11'd101, 11'd51, 12'h0A0, 12'hF00);
        px("midframe_new",  11'd301, 11'd51, 12'h0A0, 12'h0A0);
        load_pos(12'd300, 12'd50);
        px("nextframe_new", 11'd301, 11'd51, 12'h0A0, 12'hF00);
        px("nextframe_old", 11'd101, 11'd51, 12'h0A0, 12'h0A0);
        px("nextframe_crn", 11'd300, 11'd50, 12'h0A0, EDGE_EXP);

        // Right-edge clipping: no wrap to column 0.
        load_pos(12'd4080, 12'd0);
        for (int h = 0; h < 32; h++) begin
            px("nowrap", 11'(h), 11'd10, 12'h0A0, 12'h0A0);
        end

        // Reset coinciding with a vblnk rising edge: reset wins, no load.
        drive(11'd120, 11'd80, 1'b0, 1'b0, 12'h0A0);
        tick();
        xpos = 12'd100;
        ypos = 12'd50;
        rst_n = 1'b0;
        vif.vblnk_in = 1'b1;
        tick();
        chk("midrst_rgb",    {4'h0, vif.rgb_out},    16'h0);
        chk("midrst_hcount", {5'h0, vif.hcount_out}, 16'h0);
        chk("midrst_vcount", {5'h0, vif.vcount_out}, 16'h0);
        rst_n = 1'b1;
        px("postrst_origin", 11'd1,   11'd1,  12'h0A0, 12'hF00);
        px("postrst_in",     11'd40,  11'd60, 12'h0A0, 12'hF00);
        px("postrst_noload", 11'd101, 11'd51, 12'h0A0, 12'h0A0);
        load_pos(12'd100, 12'd50);
        px("reload_corner",  11'd100, 11'd50, 12'h0A0, EDGE_EXP);
        px("reload_inner",   11'd101, 11'd51, 12'h0A0, 12'hF00);
        px("reload_origin",  11'd40,  11'd60, 12'h0A0, 12'h0A0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
